// File: rtl/ensemble_pkg.sv
// Shared constants and types for the ensemble vote combiner: default class-ID
// width, combined-beat field positions and the vote result record.
package ensemble_pkg;

  localparam int CLASS_WIDTH_DEF = 8;
  // Widest class ID the vote record can carry.
  localparam int MAX_CLASS_WIDTH = 16;
  localparam int WINNER_LSB      = 0;

  function automatic int agree_lsb(input int class_width);
    return WINNER_LSB + class_width;
  endfunction

  function automatic int tie_bit(input int class_width);
    return agree_lsb(class_width) + 2;
  endfunction

  localparam int AGREE_LSB = agree_lsb(CLASS_WIDTH_DEF);
  localparam int TIE_BIT   = tie_bit(CLASS_WIDTH_DEF);

  typedef struct packed {
    logic [MAX_CLASS_WIDTH-1:0] winner;
    logic [1:0]                 agree;
    logic                       tie;
  } vote_result_t;

endpackage

// File: rtl/ensemble_vote_fifo.sv
// Per-classifier result FIFO. The read head is presented combinationally, and
// write readiness depends only on registered occupancy (and is held low during reset).
module ensemble_vote_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             wr_en;
  logic             rd_en;

  // Extra pointer MSB separates the full and empty cases when the index bits match.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_ready_o = ~full & ~rst;
  assign wr_en      = wr_valid_i & wr_ready_o;
  assign rd_en      = rd_en_i & ~empty_o;
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ensemble_vote_combiner.sv
// Joins the three classifier result streams, pops one beat from each together,
// and emits a registered majority-vote beat with running statistics.
module ensemble_vote_combiner
  import ensemble_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = CLASS_WIDTH_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
  input  logic                  s_axis_tvalid_0,
  output logic                  s_axis_tready_0,
  input  logic                  s_axis_tlast_0,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           result_count,
  output logic [15:0]           tie_count,
  output logic                  tlast_mismatch
);

  localparam int EW        = CLASS_WIDTH + 1;
  localparam int AGREE_POS = agree_lsb(CLASS_WIDTH);
  localparam int TIE_POS   = tie_bit(CLASS_WIDTH);

  // Handshake rule on every port: a beat transfers on a rising clk edge where
  // tvalid and tready are both high; a valid beat is held unchanged until then.
  logic [2:0]             in_valid;
  logic [2:0]             in_ready;
  logic [2:0]             in_empty;
  logic [2:0]             head_last;
  logic [EW-1:0]          in_beat [3];
  logic [EW-1:0]          head    [3];
  logic [CLASS_WIDTH-1:0] cls_a, cls_b, cls_c;
  logic                   pop;
  vote_result_t           vote;
  logic [DATA_WIDTH-1:0]  beat_data;

  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic [31:0]           result_count_q, result_count_d;
  logic [15:0]           tie_count_q, tie_count_d;
  logic                  mismatch_q, mismatch_d;
  logic                  unused_ok;

  assign in_valid   = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
  assign in_beat[0] = {s_axis_tlast_0, s_axis_tdata_0[CLASS_WIDTH-1:0]};
  assign in_beat[1] = {s_axis_tlast_1, s_axis_tdata_1[CLASS_WIDTH-1:0]};
  assign in_beat[2] = {s_axis_tlast_2, s_axis_tdata_2[CLASS_WIDTH-1:0]};
  assign s_axis_tready_0 = in_ready[0];
  assign s_axis_tready_1 = in_ready[1];
  assign s_axis_tready_2 = in_ready[2];

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    ensemble_vote_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_valid_i (in_valid[g]),
      .wr_data_i  (in_beat[g]),
      .wr_ready_o (in_ready[g]),
      .rd_en_i    (pop),
      .rd_data_o  (head[g]),
      .empty_o    (in_empty[g])
    );
  end

  assign cls_a     = head[0][CLASS_WIDTH-1:0];
  assign cls_b     = head[1][CLASS_WIDTH-1:0];
  assign cls_c     = head[2][CLASS_WIDTH-1:0];
  assign head_last = {head[2][CLASS_WIDTH], head[1][CLASS_WIDTH], head[0][CLASS_WIDTH]};
  assign pop       = ~|in_empty & (~m_valid_q | m_axis_tready);

  // Input 0 wins whenever it has any partner, and also breaks a three-way tie.
  always_comb begin
    vote = '0;
    if (cls_a == cls_b || cls_a == cls_c) begin
      vote.winner = MAX_CLASS_WIDTH'(cls_a);
      vote.agree  = 2'd1 + {1'b0, cls_a == cls_b} + {1'b0, cls_a == cls_c};
    end else if (cls_b == cls_c) begin
      vote.winner = MAX_CLASS_WIDTH'(cls_b);
      vote.agree  = 2'd2;
    end else begin
      vote.winner = MAX_CLASS_WIDTH'(cls_a);
      vote.agree  = 2'd1;
      vote.tie    = 1'b1;
    end
  end

  always_comb begin
    beat_data = '0;
    beat_data[WINNER_LSB +: CLASS_WIDTH] = vote.winner[CLASS_WIDTH-1:0];
    beat_data[AGREE_POS +: 2]            = vote.agree;
    beat_data[TIE_POS]                   = vote.tie;
  end

  always_comb begin
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    m_last_d       = m_last_q;
    result_count_d = result_count_q;
    tie_count_d    = tie_count_q;
    mismatch_d     = mismatch_q;
    if (m_valid_q && m_axis_tready) begin
      m_valid_d      = 1'b0;
      result_count_d = result_count_q + 32'd1;
    end
    if (pop) begin
      m_valid_d = 1'b1;
      m_data_d  = beat_data;
      m_last_d  = head_last[0];
      if (vote.tie && tie_count_q != 16'hFFFF) tie_count_d = tie_count_q + 16'd1;
      if (!(&head_last) && (|head_last)) mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      m_last_q       <= 1'b0;
      result_count_q <= '0;
      tie_count_q    <= '0;
      mismatch_q     <= 1'b0;
    end else begin
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_last_q       <= m_last_d;
      result_count_q <= result_count_d;
      tie_count_q    <= tie_count_d;
      mismatch_q     <= mismatch_d;
    end
  end

  assign m_axis_tvalid  = m_valid_q;
  assign m_axis_tdata   = m_data_q;
  assign m_axis_tlast   = m_last_q;
  assign m_axis_tkeep   = {KEEP_WIDTH{m_valid_q}};
  assign result_count   = result_count_q;
  assign tie_count      = tie_count_q;
  assign tlast_mismatch = mismatch_q;

  // tkeep and the upper tdata bits are accepted but carry nothing we store.
  assign unused_ok = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                       s_axis_tdata_0[DATA_WIDTH-1:CLASS_WIDTH],
                       s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                       s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH],
                       vote.winner};

endmodule

// File: tb/tb_ensemble_vote_combiner.sv
// Bench for ensemble_vote_combiner: random per-input streams, a behavioural
// vote/occupancy model with an expected-beat queue, and directed scenarios.
module tb_ensemble_vote_combiner;

  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int CW    = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data [3];
  logic [KW-1:0] s_keep [3];
  logic [2:0]    s_valid;
  logic [2:0]    s_last;
  logic [2:0]    s_ready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [31:0]   result_count;
  logic [15:0]   tie_count;
  logic          tlast_mismatch;

  ensemble_vote_combiner #(
    .DATA_WIDTH (DW), .KEEP_WIDTH (KW), .CLASS_WIDTH (CW), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst (rst),
    .s_axis_tdata_0 (s_data[0]), .s_axis_tkeep_0 (s_keep[0]), .s_axis_tvalid_0 (s_valid[0]),
    .s_axis_tready_0 (s_ready[0]), .s_axis_tlast_0 (s_last[0]),
    .s_axis_tdata_1 (s_data[1]), .s_axis_tkeep_1 (s_keep[1]), .s_axis_tvalid_1 (s_valid[1]),
    .s_axis_tready_1 (s_ready[1]), .s_axis_tlast_1 (s_last[1]),
    .s_axis_tdata_2 (s_data[2]), .s_axis_tkeep_2 (s_keep[2]), .s_axis_tvalid_2 (s_valid[2]),
    .s_axis_tready_2 (s_ready[2]), .s_axis_tlast_2 (s_last[2]),
    .m_axis_tdata (m_tdata), .m_axis_tkeep (m_tkeep), .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready), .m_axis_tlast (m_tlast),
    .result_count (result_count), .tie_count (tie_count), .tlast_mismatch (tlast_mismatch)
  );

  // ---------------- bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beats waiting to be offered ({tlast, class}) and beats actually accepted.
  logic [CW:0] src0[$], src1[$], src2[$];
  logic [CW:0] h0[$], h1[$], h2[$];
  logic [DW:0] exp_q[$];
  logic [DW:0] out_log[$];
  int          n_hs     = 0;
  int          n_loaded = 0;
  logic [15:0] tie_exp  = '0;
  logic        mm_exp   = 1'b0;

  int   gap_pct    = 0;
  int   ready_mode = 1;
  logic [2:0] hold = 3'b000;

  function automatic int src_size(input int k);
    case (k)
      0:       return src0.size();
      1:       return src1.size();
      default: return src2.size();
    endcase
  endfunction

  function automatic logic [CW:0] src_front(input int k);
    case (k)
      0:       return src0[0];
      1:       return src1[0];
      default: return src2[0];
    endcase
  endfunction

  task automatic src_pop(input int k);
    if (src_size(k) == 0) return;
    case (k)
      0:       void'(src0.pop_front());
      1:       void'(src1.pop_front());
      default: void'(src2.pop_front());
    endcase
  endtask

  task automatic push_triple(input logic [CW-1:0] a, input logic la,
                             input logic [CW-1:0] b, input logic lb,
                             input logic [CW-1:0] c, input logic lc);
    src0.push_back({la, a});
    src1.push_back({lb, b});
    src2.push_back({lc, c});
  endtask

  task automatic clear_src();
    src0.delete(); src1.delete(); src2.delete();
  endtask

  function automatic int h_size(input int k);
    case (k)
      0:       return h0.size();
      1:       return h1.size();
      default: return h2.size();
    endcase
  endfunction

  function automatic logic [CW:0] h_get(input int k, input int idx);
    case (k)
      0:       return h0[idx];
      1:       return h1[idx];
      default: return h2[idx];
    endcase
  endfunction

  // Majority by counting matches: a value seen at least twice wins; otherwise
  // input 0's value is reported as a tie with agreement 1.
  function automatic logic [DW-1:0] exp_word(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                             input logic [CW-1:0] c);
    int ca, cb, win, agr, tie;
    ca = 1 + int'(a == b) + int'(a == c);
    cb = 1 + int'(b == a) + int'(b == c);
    if (ca >= 2)      begin win = int'(a); agr = ca; tie = 0; end
    else if (cb >= 2) begin win = int'(b); agr = cb; tie = 0; end
    else              begin win = int'(a); agr = 1;  tie = 1; end
    return DW'(win + agr * 256 + tie * 1024);
  endfunction

  // ---------------- input drivers (one process for all three channels)
  initial begin
    logic [2:0]    hs;
    logic [CW:0]   beat;
    logic [DW-1:0] r;
    s_valid = '0;
    s_last  = '0;
    for (int k = 0; k < 3; k++) begin s_data[k] = '0; s_keep[k] = '0; end
    forever begin
      @(negedge clk);
      hs = s_valid & s_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          s_valid[k] = 1'b0;
        end else begin
          if (hs[k]) begin
            s_valid[k] = 1'b0;
            src_pop(k);
          end
          if (!s_valid[k] && !hold[k] && src_size(k) > 0 &&
              int'($urandom_range(0, 99)) >= gap_pct) begin
            beat        = src_front(k);
            r           = $urandom;
            r[CW-1:0]   = beat[CW-1:0];
            s_data[k]   = r;
            s_last[k]   = beat[CW];
            s_keep[k]   = KW'($urandom);
            s_valid[k]  = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- downstream ready
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = ~m_tready;
      endcase
    end
  end

  // ---------------- scoreboard / compare, every cycle
  always @(negedge clk) begin
    int occ [3];
    logic pop_now;
    logic [CW:0] a, b, c;
    logic [DW-1:0] w;
    if (rst) begin
      chk("reset_out", {m_tvalid, m_tdata, m_tkeep, m_tlast}, '0);
      chk("reset_stat", {result_count, tie_count, tlast_mismatch, s_ready}, '0);
      h0.delete(); h1.delete(); h2.delete();
      exp_q.delete(); out_log.delete();
      n_hs = 0; n_loaded = 0; tie_exp = '0; mm_exp = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) occ[k] = h_size(k) - n_loaded;
      chk("m_tkeep", m_tkeep, m_tvalid ? 4'hF : 4'h0);
      chk("m_tvalid", m_tvalid, exp_q.size() != 0);
      if (m_tvalid && exp_q.size() != 0) chk("m_beat", {m_tlast, m_tdata}, exp_q[0]);
      for (int k = 0; k < 3; k++)
        chk($sformatf("s_tready_%0d", k), s_ready[k], occ[k] < DEPTH);
      chk("result_count", result_count, 32'(n_hs));
      chk("tie_count", tie_count, tie_exp);
      chk("tlast_mismatch", tlast_mismatch, mm_exp);

      pop_now = occ[0] > 0 && occ[1] > 0 && occ[2] > 0 && (exp_q.size() == 0 || m_tready);
      if (m_tvalid && m_tready) begin
        n_hs++;
        out_log.push_back({m_tlast, m_tdata});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (pop_now) begin
        a = h_get(0, n_loaded);
        b = h_get(1, n_loaded);
        c = h_get(2, n_loaded);
        w = exp_word(a[CW-1:0], b[CW-1:0], c[CW-1:0]);
        exp_q.push_back({a[CW], w});
        if (w[10] && tie_exp != 16'hFFFF) tie_exp = tie_exp + 16'd1;
        if (a[CW] != b[CW] || b[CW] != c[CW]) mm_exp = 1'b1;
        n_loaded++;
      end
      if (s_valid[0] && s_ready[0]) h0.push_back({s_last[0], s_data[0][CW-1:0]});
      if (s_valid[1] && s_ready[1]) h1.push_back({s_last[1], s_data[1][CW-1:0]});
      if (s_valid[2] && s_ready[2]) h2.push_back({s_last[2], s_data[2][CW-1:0]});
    end
  end

  // ---------------- main sequence
  task automatic wait_drain(input int target, input int budget);
    int cyc = 0;
    while (!(n_hs == target && src0.size() == 0 && src1.size() == 0 && src2.size() == 0 &&
             exp_q.size() == 0 && s_valid == 3'b000) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain", n_hs, target);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    clear_src();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] held;
    int t;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Latency and first result: 5,5,9 -> winner 5, agree 2.
    ready_mode = 1;
    gap_pct    = 0;
    push_triple(8'd5, 1'b0, 8'd5, 1'b0, 8'd9, 1'b0);
    t = 0;
    do begin
      @(posedge clk);
      #2;
      t++;
    end while ((src0.size() + src1.size() + src2.size()) != 0 && t < 20);
    chk("lat_inputs_taken", src0.size() + src1.size() + src2.size(), 0);
    @(negedge clk);
    chk("lat_cycle1_valid", m_tvalid, 1'b0);
    @(negedge clk);
    chk("lat_cycle2_valid", m_tvalid, 1'b1);
    chk("lat_cycle2_data", m_tdata, 32'h0000_0205);
    wait_drain(1, 50);
    chk("t1_result_count", result_count, 32'd1);

    // Two-way majority on inputs 1/2, then a three-way tie.
    push_triple(8'd3, 1'b0, 8'd7, 1'b0, 8'd7, 1'b0);
    push_triple(8'd1, 1'b0, 8'd2, 1'b0, 8'd4, 1'b0);
    wait_drain(3, 100);
    chk("t2_beat0", out_log[0][DW-1:0], 32'h0000_0205);
    chk("t2_beat1", out_log[1][DW-1:0], 32'h0000_0207);
    chk("t2_beat2", out_log[2][DW-1:0], 32'h0000_0501);
    chk("t2_tie_count", tie_count, 16'd1);

    // 100 random beats, input 1 starts 10 cycles late, downstream ready toggles.
    apply_reset();
    ready_mode = 2;
    gap_pct    = 30;
    hold[1]    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic l;
      l = 1'($urandom_range(0, 1));
      push_triple(CW'($urandom_range(0, 3)), l, CW'($urandom_range(0, 3)), l,
                  CW'($urandom_range(0, 3)), l);
    end
    repeat (10) @(posedge clk);
    #3 hold[1] = 1'b0;
    wait_drain(100, 5000);
    chk("t3_result_count", result_count, 32'd100);

    // Downstream stalled: 4 beats per FIFO plus one in the output register.
    @(posedge clk);
    #3 ready_mode = 0;
    gap_pct = 0;
    for (int i = 0; i < 8; i++)
      push_triple(CW'(i), 1'b0, CW'(i + 1), 1'b0, CW'(i), 1'b0);
    repeat (15) @(negedge clk);
    chk("stall_tready", s_ready, 3'b000);
    chk("stall_src_left", src0.size() * 100 + src1.size() * 10 + src2.size(), 333);
    chk("stall_valid", m_tvalid, 1'b1);
    held = m_tdata;
    repeat (5) @(negedge clk);
    chk("stall_hold", m_tdata, held);
    @(posedge clk);
    #3 ready_mode = 1;
    wait_drain(108, 500);

    // tlast disagreement is reported and stays sticky.
    chk("t5_mismatch_before", tlast_mismatch, 1'b0);
    push_triple(8'd4, 1'b1, 8'd4, 1'b1, 8'd6, 1'b0);
    push_triple(8'd1, 1'b0, 8'd1, 1'b0, 8'd1, 1'b0);
    push_triple(8'd2, 1'b1, 8'd2, 1'b1, 8'd2, 1'b1);
    wait_drain(111, 200);
    chk("t5_tlast", out_log[108][DW], 1'b1);
    chk("t5_mismatch_sticky", tlast_mismatch, 1'b1);

    // Reset with data buffered and inputs still valid.
    @(posedge clk);
    #3 ready_mode = 0;
    for (int i = 0; i < 6; i++)
      push_triple(CW'(10 + i), 1'b0, CW'(10 + i), 1'b0, CW'(20 + i), 1'b0);
    repeat (15) @(negedge clk);
    chk("t6_pre_valid", m_tvalid, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    clear_src();
    #1;
    chk("t6_async_out", {m_tvalid, m_tdata, m_tkeep, m_tlast}, '0);
    chk("t6_async_stat", {result_count, tie_count, tlast_mismatch, s_ready}, '0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    ready_mode = 1;
    repeat (10) @(negedge clk);
    chk("t6_no_stale", m_tvalid, 1'b0);
    chk("t6_count_zero", result_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
